// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the counter op scheduler.
// Opcodes, FSM states and the op-apply function.
package counter_sched_pkg;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_ADD2 = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  // Result is truncated by the caller, so wrap is modulo 2^WIDTH.
  function automatic logic [31:0] apply_op(
    input logic [31:0] v,
    input logic [1:0]  op
  );
    logic [31:0] r;
    r = v;
    unique case (op)
      OP_INC:  r = v + 32'd1;
      OP_DEC:  r = v - 32'd1;
      OP_ADD2: r = v + 32'd2;
      OP_CLR:  r = 32'd0;
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/counter_op_scheduler_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Picks the first valid index at or after ptr.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr_next
);

  logic [PW-1:0] idx;
  logic          found;

  // Scan N positions starting at ptr; first valid wins.
  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = (int'(idx) == N - 1) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_op_scheduler.sv
// Shared-counter scheduler: pending slots, RR service,
// optional gap between ops, sticky drop flags.
module counter_op_scheduler
  import counter_sched_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic                 ovf_clr,
  output logic [WIDTH-1:0]     count,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   ovf,
  output logic                 busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GLOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   valid_q, valid_d;
  logic [2*NUM_REQ-1:0] op_q, op_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ovf_q, ovf_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [PW-1:0]      arb_ptr;
  logic               issue_en;
  logic [1:0]         sel_op;
  logic [NUM_REQ-1:0] ovf_set;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_arb (
    .valid    (valid_q),
    .ptr      (ptr_q),
    .grant    (arb_grant),
    .ptr_next (arb_ptr)
  );

  // IDLE also issues so an uncontended op lands in 2 cycles.
  assign issue_en = (state_q != S_GAP) && (|valid_q);

  // Select the op of the granted slot.
  always_comb begin
    sel_op = OP_INC;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (issue_en && arb_grant[i]) begin
        sel_op = op_q[2*i +: 2];
      end
    end
  end

  // Slot load/clear, drop detection and sticky overflow.
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    ovf_set = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (issue_en && arb_grant[i]) begin
        valid_d[i] = 1'b0;
      end
      if (req[i]) begin
        if (!valid_q[i] || (issue_en && arb_grant[i])) begin
          valid_d[i]      = 1'b1;
          op_d[2*i +: 2]  = req_op[2*i +: 2];
        end else begin
          ovf_set[i] = 1'b1;
        end
      end
    end
    ovf_d = (ovf_clr ? '0 : ovf_q) | ovf_set;
  end

  // Counter, grant pulse, pointer and busy next values.
  always_comb begin
    count_d = count_q;
    grant_d = '0;
    ptr_d   = ptr_q;
    if (issue_en) begin
      count_d = WIDTH'(apply_op(32'(count_q), sel_op));
      grant_d = arb_grant;
      ptr_d   = arb_ptr;
    end
    busy_d = (|valid_q) || (state_q == S_GAP);
  end

  // FSM next state and gap down-counter.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE, S_ISSUE: begin
        if (issue_en) begin
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            gap_d   = GW'(GLOAD);
          end else begin
            state_d = (|valid_d) ? S_ISSUE : S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = (|valid_d) ? S_ISSUE : S_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gap_d   = '0;
      end
    endcase
  end

  // All state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      op_q    <= '0;
      ptr_q   <= '0;
      gap_q   <= '0;
      count_q <= '0;
      grant_q <= '0;
      ovf_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      count_q <= count_d;
      grant_q <= grant_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign count = count_q;
  assign grant = grant_q;
  assign ovf   = ovf_q;
  assign busy  = busy_q;

endmodule
